// File: rtl/alu_seq.sv
// Sequential multi-cycle ALU: single-cycle logic/arithmetic ops, bit-serial rotate, optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (op 1001); otherwise 1001 is a NOP and result_hi is 0.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op_select,
    input  logic [WIDTH-1:0] AC,
    input  logic [WIDTH-1:0] DR,
    input  logic             E,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             CO,
    output logic             OVF,
    output logic             N,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int CW   = $clog2(WIDTH + 1);
    localparam int CNTW = (SHW > CW) ? SHW : CW;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_TRF = 4'b0011;
    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_ROR = 4'b1000;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1001;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        op_reg;
    logic [WIDTH-1:0]  ac_reg, dr_reg, work_reg;
    logic              e_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              co_reg, ovf_reg, n_reg, z_reg;

    logic              finish, upd;
    logic [WIDTH-1:0]  res_val;
    logic              co_val, ovf_val;
    logic [WIDTH:0]    add_sum, sub_sum;
    logic [WIDTH-1:0]  rot1;

    assign add_sum = {1'b0, ac_reg} + {1'b0, dr_reg} + {{WIDTH{1'b0}}, e_reg};
    assign sub_sum = {1'b0, ac_reg} + {1'b0, ~dr_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign rot1    = {work_reg[0], work_reg[WIDTH-1:1]};

`ifdef ALU_SEQ_MUL_EN
    // work_reg is the running high half; mlo_reg shifts the multiplier out and the low product in
    logic [WIDTH-1:0] hi_reg, hi_val, mlo_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_step, mul_lo_step;

    assign mul_sum     = {1'b0, work_reg} + (mlo_reg[0] ? {1'b0, ac_reg} : {(WIDTH+1){1'b0}});
    assign mul_hi_step = mul_sum[WIDTH:1];
    assign mul_lo_step = {mul_sum[0], mlo_reg[WIDTH-1:1]};
    assign result_hi   = hi_reg;
`else
    assign result_hi   = '0;
`endif

    assign result = result_reg;
    assign CO     = co_reg;
    assign OVF    = ovf_reg;
    assign N      = n_reg;
    assign Z      = z_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        finish     = 1'b1;
        if (op_reg == OP_ROR) finish = (cnt_reg <= CNTW'(1));
`ifdef ALU_SEQ_MUL_EN
        if (op_reg == OP_MUL) finish = (cnt_reg == CNTW'(1));
`endif
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (finish) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        upd     = 1'b1;
        res_val = result_reg;
        co_val  = co_reg;
        ovf_val = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        hi_val  = '0;
`endif
        case (op_reg)
            OP_ADD: begin
                res_val = add_sum[WIDTH-1:0];
                co_val  = add_sum[WIDTH];
                ovf_val = (ac_reg[WIDTH-1] == dr_reg[WIDTH-1]) && (add_sum[WIDTH-1] != ac_reg[WIDTH-1]);
            end
            OP_AND: res_val = ac_reg & dr_reg;
            OP_TRF: res_val = dr_reg;
            OP_CMP: res_val = ~ac_reg;
            OP_SHR: begin
                res_val = {e_reg, ac_reg[WIDTH-1:1]};
                co_val  = ac_reg[0];
            end
            OP_SHL: begin
                res_val = {ac_reg[WIDTH-2:0], e_reg};
                co_val  = ac_reg[WIDTH-1];
            end
            OP_SUB: begin
                res_val = sub_sum[WIDTH-1:0];
                co_val  = sub_sum[WIDTH];
                ovf_val = (ac_reg[WIDTH-1] != dr_reg[WIDTH-1]) && (sub_sum[WIDTH-1] != ac_reg[WIDTH-1]);
            end
            // a zero count finishes without rotating
            OP_ROR: res_val = (cnt_reg == '0) ? work_reg : rot1;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                res_val = mul_lo_step;
                hi_val  = mul_hi_step;
                co_val  = |mul_hi_step;
            end
`endif
            default: upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= '0;
            ac_reg     <= '0;
            dr_reg     <= '0;
            e_reg      <= 1'b0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            co_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            n_reg      <= 1'b0;
            z_reg      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_reg     <= '0;
            mlo_reg    <= '0;
`endif
        end else if (state_reg == IDLE && start) begin
            op_reg   <= op_select;
            ac_reg   <= AC;
            dr_reg   <= DR;
            e_reg    <= E;
            work_reg <= AC;
            cnt_reg  <= CNTW'(DR[SHW-1:0]);
`ifdef ALU_SEQ_MUL_EN
            mlo_reg  <= DR;
            if (op_select == OP_MUL) begin
                work_reg <= '0;
                cnt_reg  <= CNTW'(WIDTH);
            end
`endif
        end else if (state_reg == RUN) begin
            if (!finish) begin
                cnt_reg <= cnt_reg - CNTW'(1);
                if (op_reg == OP_ROR) work_reg <= rot1;
`ifdef ALU_SEQ_MUL_EN
                if (op_reg == OP_MUL) begin
                    work_reg <= mul_hi_step;
                    mlo_reg  <= mul_lo_step;
                end
`endif
            end else if (upd) begin
                result_reg <= res_val;
                co_reg     <= co_val;
                ovf_reg    <= ovf_val;
                n_reg      <= res_val[WIDTH-1];
                z_reg      <= (res_val == '0);
`ifdef ALU_SEQ_MUL_EN
                hi_reg     <= hi_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (WIDTH=16) against an arithmetic reference model via a scoreboard queue.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op_select;
    logic [15:0] AC, DR;
    logic        E;
    logic [15:0] result, result_hi;
    logic        CO, OVF, N, Z, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        co, ovf, n, z;
        int          run;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_res, m_hi;
    logic        m_co, m_ovf, m_n, m_z;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_select(op_select),
        .AC(AC), .DR(DR), .E(E), .result(result), .result_hi(result_hi),
        .CO(CO), .OVF(OVF), .N(N), .Z(Z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: plain integer arithmetic, updates the tracked output state
    function automatic int model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d, input logic e);
        logic [16:0] s;
        logic [31:0] t;
        logic [63:0] p;
        int sr;
        int run = 1;
        case (op)
            4'd1: begin
                s = {1'b0, a} + {1'b0, d} + {16'd0, e};
                sr = int'($signed(a)) + int'($signed(d)) + int'(e);
                m_res = s[15:0]; m_co = s[16]; m_ovf = (sr > 32767 || sr < -32768); m_hi = '0;
            end
            4'd2: begin m_res = a & d; m_ovf = 1'b0; m_hi = '0; end
            4'd3: begin m_res = d; m_ovf = 1'b0; m_hi = '0; end
            4'd4: begin m_res = ~a; m_ovf = 1'b0; m_hi = '0; end
            4'd5: begin m_res = {e, a[15:1]}; m_co = a[0]; m_ovf = 1'b0; m_hi = '0; end
            4'd6: begin m_res = {a[14:0], e}; m_co = a[15]; m_ovf = 1'b0; m_hi = '0; end
            4'd7: begin
                sr = int'($signed(a)) - int'($signed(d));
                m_res = a - d; m_co = (a >= d); m_ovf = (sr > 32767 || sr < -32768); m_hi = '0;
            end
            4'd8: begin
                t = {a, a} >> d[3:0];
                m_res = t[15:0]; m_ovf = 1'b0; m_hi = '0;
                run = (d[3:0] == 4'd0) ? 1 : int'(d[3:0]);
            end
`ifdef ALU_SEQ_MUL_EN
            4'd9: begin
                p = 64'(a) * 64'(d);
                m_res = p[15:0]; m_hi = p[31:16]; m_co = (p[31:16] != 16'd0); m_ovf = 1'b0;
                run = 16;
            end
`endif
            default: begin end
        endcase
        m_n = m_res[15];
        m_z = (m_res == 16'd0);
        return run;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] d,
                          input logic e, input bit glitch);
        exp_t x;
        exp_t y;
        int edges;
        int bcnt;
        x.run = model(op, a, d, e);
        x.res = m_res; x.hi = m_hi; x.co = m_co; x.ovf = m_ovf; x.n = m_n; x.z = m_z;
        sb.push_back(x);
        @(negedge clk);
        op_select = op; AC = a; DR = d; E = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        AC = 16'($urandom); DR = 16'($urandom); E = 1'($urandom); op_select = 4'($urandom);
        edges = 1;
        bcnt = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) bcnt++;
            start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        if (busy === 1'b1) bcnt++;
        chk("done_latency", 64'(edges), 64'(x.run + 1));
        chk("busy_cycles", 64'(bcnt), 64'(x.run + 1));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(0), 64'(1));
        end else begin
            y = sb.pop_front();
            chk("result", 64'(result), 64'(y.res));
            chk("result_hi", 64'(result_hi), 64'(y.hi));
            chk("CO", 64'(CO), 64'(y.co));
            chk("OVF", 64'(OVF), 64'(y.ovf));
            chk("N", 64'(N), 64'(y.n));
            chk("Z", 64'(Z), 64'(y.z));
        end
        $display("op=%h AC=%h DR=%h E=%b -> result=%h hi=%h CO=%b OVF=%b N=%b Z=%b cycles=%0d",
                 op, a, d, e, result, result_hi, CO, OVF, N, Z, edges);
        @(negedge clk);
        chk("done_pulse_end", 64'(done), 64'(0));
        chk("idle_not_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_select = '0; AC = '0; DR = '0; E = 1'b0;
        m_res = '0; m_hi = '0; m_co = 1'b0; m_ovf = 1'b0; m_n = 1'b0; m_z = 1'b0;
        #1;
        chk("rst_outputs", {result, result_hi, CO, OVF, N, Z, busy, done}, 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0001, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("add_ovf_result", 64'(result), 64'h8000);
        run_op(4'b0111, 16'h0005, 16'h0005, 1'b1, 1'b0);
        run_op(4'b0111, 16'h0000, 16'h0001, 1'b0, 1'b0);
        chk("sub_borrow_result", 64'(result), 64'hFFFF);
        run_op(4'b0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(4'b0010, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
        run_op(4'b0011, 16'h1234, 16'h8001, 1'b0, 1'b0);
        run_op(4'b0100, 16'h00FF, 16'h0000, 1'b0, 1'b0);
        run_op(4'b0101, 16'h0003, 16'h0000, 1'b1, 1'b0);
        run_op(4'b0110, 16'h8000, 16'h0000, 1'b0, 1'b0);
        run_op(4'b1000, 16'h0001, 16'h0004, 1'b0, 1'b0);
        chk("ror4_result", 64'(result), 64'h1000);
        run_op(4'b1000, 16'h0001, 16'h0000, 1'b0, 1'b0);
        run_op(4'b1000, 16'hA5C3, 16'h000F, 1'b0, 1'b1);
        run_op(4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_op(4'b1111, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_op(4'b1001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        run_op(4'b1001, 16'h1234, 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // abort a long operation with reset; no done may appear
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        op_select = 4'b1001; AC = 16'hFFFF; DR = 16'hFFFF;
`else
        op_select = 4'b1000; AC = 16'h8001; DR = 16'h000F;
`endif
        E = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_op_outputs", {result, result_hi, CO, OVF, N, Z, busy, done}, 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        m_res = '0; m_hi = '0; m_co = 1'b0; m_ovf = 1'b0; m_n = 1'b0; m_z = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
        end
        run_op(4'b0001, 16'h0002, 16'h0003, 1'b0, 1'b0);
        chk("post_rst_add", 64'(result), 64'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), the width of the rotate-count field taken from DR.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op_select  input  4  operation code (see REQ-012).
REQ-007 AC, DR  input  WIDTH  operands; E  input  1  carry/link in.
REQ-008 result  output  WIDTH  registered low result; result_hi  output  WIDTH  registered multiply high half.
REQ-009 CO, OVF, N, Z  output  1 each  registered flags: carry/link out, signed overflow, negative, zero.
REQ-010 busy  output  1  high while not IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and FIN: IDLE->RUN on start; RUN->FIN when the op completes; FIN->IDLE unconditionally; done=1 in FIN only; busy=1 in RUN and FIN.
REQ-012 SHALL latch AC, DR, E and op_select on start acceptance; input changes while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-013 Op codes:
- 0001 ADD: {CO,result}=AC+DR+E.
- 0010 AND.
- 0011 TRANSFER DR.
- 0100 COMPLEMENT ~AC.
- 0101 SHR: result={E,AC[W-1:1]}, CO=AC[0].
- 0110 SHL: result={AC[W-2:0],E}, CO=AC[W-1].
- 0111 SUB: {CO,result}=AC+~DR+1, with CO=1 meaning no borrow.
- 1000 ROR: AC rotated right by DR[SHW-1:0].
- 1001 MUL: unsigned AC*DR, result=low half, result_hi=high half, CO=|high half.
- All other codes: NOP.
REQ-014 Single-cycle ops (ADD, AND, TRANSFER, COMPLEMENT, SHR, SHL, SUB, NOP) SHALL spend exactly 1 cycle in RUN, so done asserts 2 cycles after the start edge.
REQ-015 ROR SHALL rotate one bit per RUN cycle, taking max(count,1) RUN cycles; count 0 SHALL return AC unchanged.
REQ-016 MUL SHALL use iterative shift-add, one multiplier bit per cycle, spending exactly WIDTH cycles in RUN.
REQ-017 OVF SHALL be the signed overflow of ADD (operand signs equal, result sign different) and of SUB (operand signs differ, result sign differs from AC); OVF SHALL be 0 for all other ops.
REQ-018 Flag rules:
- CO SHALL hold its previous value for AND, TRANSFER, COMPLEMENT, ROR and NOP.
- result_hi SHALL be cleared by every non-MUL op except NOP.
- NOP SHALL leave result, result_hi and all flags unchanged.
REQ-019 Z=(result==0) and N=result[WIDTH-1]; all outputs SHALL update only on the RUN->FIN edge and hold stable until the next completion.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH; E in SUB SHALL be ignored.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, result=0, result_hi=0, CO=OVF=N=Z=0, busy=0, done=0.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-023 Macro ALU_SEQ_MUL_EN: when defined, op 1001 is MUL per REQ-016.
REQ-024 When ALU_SEQ_MUL_EN is undefined, no multiplier logic SHALL exist, 1001 SHALL behave as NOP, and result_hi SHALL be tied to 0.

Verification
REQ-025 WIDTH=16, ADD AC=7FFF, DR=0001, E=0 -> result=8000, CO=0, OVF=1, N=1, Z=0, done 2 cycles after start.
REQ-026 SUB AC=0005, DR=0005 -> result=0000, Z=1, CO=1, OVF=0; then SUB AC=0000, DR=0001 -> result=FFFF, CO=0, N=1.
REQ-027 ROR AC=0001, DR=0004 -> result=1000 after 4 RUN cycles, CO unchanged; DR=0000 -> result=0001 after 1 RUN cycle.
REQ-028 ALU_SEQ_MUL_EN defined, MUL AC=FFFF, DR=FFFF -> result=0001, result_hi=FFFE, CO=1, busy for 17 cycles; start pulses during busy are ignored.
REQ-029 Reset asserted mid-MUL -> all outputs 0, no done; next ADD 0002+0003 -> result=0005.
